// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way traffic light sequencer.
// States FLASH/FLASH_EXIT exist only when FLASH_MODE_EN is defined.
package traffic_pkg;

  localparam logic [3:0] GRE    = 4'd0;
  localparam logic [3:0] YEL    = 4'd1;
  localparam logic [3:0] RED    = 4'd2;
  localparam logic [3:0] LFTGRE = 4'd3;
  localparam logic [3:0] LFTYEL = 4'd4;
  localparam logic [3:0] ALLOFF = 4'd5;

  localparam logic [15:0] FLASH_DARK = {ALLOFF, ALLOFF, ALLOFF, ALLOFF};

  localparam int unsigned DEF_TICK_CYCLES = 100000000;
  localparam int unsigned DEF_GREEN_S     = 10;
  localparam int unsigned DEF_YELLOW_S    = 3;
  localparam int unsigned DEF_LEFT_S      = 5;
  localparam int unsigned DEF_ALLRED_S    = 1;

  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_NS_LGRN = 4'd1,
    ST_NS_LYEL = 4'd2,
    ST_NS_GRN  = 4'd3,
    ST_NS_YEL  = 4'd4,
    ST_NS_RED  = 4'd5,
    ST_EW_LGRN = 4'd6,
    ST_EW_LYEL = 4'd7,
    ST_EW_GRN  = 4'd8,
    ST_EW_YEL  = 4'd9,
    ST_EW_RED  = 4'd10
`ifdef FLASH_MODE_EN
    , ST_FLASH      = 4'd11
    , ST_FLASH_EXIT = 4'd12
`endif
  } state_e;

  // Nibble order is North, South, East, West; FLASH returns its lit pattern.
  function automatic logic [15:0] code_of(input state_e s);
    case (s)
      ST_NS_LGRN:    code_of = {LFTGRE, LFTGRE, RED, RED};
      ST_NS_LYEL:    code_of = {LFTYEL, LFTYEL, RED, RED};
      ST_NS_GRN:     code_of = {GRE, GRE, RED, RED};
      ST_NS_YEL:     code_of = {YEL, YEL, RED, RED};
      ST_EW_LGRN:    code_of = {RED, RED, LFTGRE, LFTGRE};
      ST_EW_LYEL:    code_of = {RED, RED, LFTYEL, LFTYEL};
      ST_EW_GRN:     code_of = {RED, RED, GRE, GRE};
      ST_EW_YEL:     code_of = {RED, RED, YEL, YEL};
`ifdef FLASH_MODE_EN
      ST_FLASH:      code_of = {YEL, YEL, RED, RED};
`endif
      default:       code_of = {RED, RED, RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Request/light-code bundle between the sequencer and its environment.
// flash_req is present only when FLASH_MODE_EN is defined.
interface traffic_light_ctrl_if;
  logic        ns_left_req;
  logic        ew_left_req;
  logic [15:0] light_code;
  logic [3:0]  phase;
  logic        phase_start;
`ifdef FLASH_MODE_EN
  logic        flash_req;

  modport master (output ns_left_req, ew_left_req, flash_req,
                  input  light_code, phase, phase_start);
  modport slave  (input  ns_left_req, ew_left_req, flash_req,
                  output light_code, phase, phase_start);
`else
  modport master (output ns_left_req, ew_left_req,
                  input  light_code, phase, phase_start);
  modport slave  (input  ns_left_req, ew_left_req,
                  output light_code, phase, phase_start);
`endif
endinterface

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_CYCLES clocks, realigned by restart.
module sec_tick_gen
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Four-way intersection sequencer producing the 16-bit light-code word.
// Optional flashing mode is enabled by defining FLASH_MODE_EN.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int unsigned GREEN_S     = DEF_GREEN_S,
  parameter int unsigned YELLOW_S    = DEF_YELLOW_S,
  parameter int unsigned LEFT_S      = DEF_LEFT_S,
  parameter int unsigned ALLRED_S    = DEF_ALLRED_S
) (
  input logic                 clk,
  input logic                 reset,
  traffic_light_ctrl_if.slave bus
);

  state_e      state, state_next, ns_entry, ew_entry;
  logic [7:0]  sec;
  logic        ns_pend, ew_pend;
  logic        tick, last_tick, advance;
  logic [15:0] code_next, light_code_q;
  logic        phase_start_q;
`ifdef FLASH_MODE_EN
  logic        flash_lit, flash_lit_next;
`endif

  function automatic logic [7:0] dur_of(input state_e s);
    case (s)
      ST_NS_LGRN, ST_EW_LGRN:                       dur_of = 8'(LEFT_S);
      ST_NS_LYEL, ST_NS_YEL, ST_EW_LYEL, ST_EW_YEL: dur_of = 8'(YELLOW_S);
      ST_NS_GRN, ST_EW_GRN:                         dur_of = 8'(GREEN_S);
      default:                                      dur_of = 8'(ALLRED_S);
    endcase
  endfunction

  sec_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_sec_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (advance),
    .tick    (tick)
  );

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    code_next  = '0;
    ns_entry   = ns_pend ? ST_NS_LGRN : ST_NS_GRN;
    ew_entry   = ew_pend ? ST_EW_LGRN : ST_EW_GRN;
    last_tick  = tick && (sec == dur_of(state) - 8'd1);
`ifdef FLASH_MODE_EN
    flash_lit_next = flash_lit;
`endif
    case (state)
      ST_INIT, ST_EW_RED:
        if (last_tick) begin
`ifdef FLASH_MODE_EN
          state_next = bus.flash_req ? ST_FLASH : ns_entry;
`else
          state_next = ns_entry;
`endif
        end
      ST_NS_LGRN: if (last_tick) state_next = ST_NS_LYEL;
      ST_NS_LYEL: if (last_tick) state_next = ST_NS_GRN;
      ST_NS_GRN:  if (last_tick) state_next = ST_NS_YEL;
      ST_NS_YEL:  if (last_tick) state_next = ST_NS_RED;
      ST_NS_RED:
        if (last_tick) begin
`ifdef FLASH_MODE_EN
          state_next = bus.flash_req ? ST_FLASH : ew_entry;
`else
          state_next = ew_entry;
`endif
        end
      ST_EW_LGRN: if (last_tick) state_next = ST_EW_LYEL;
      ST_EW_LYEL: if (last_tick) state_next = ST_EW_GRN;
      ST_EW_GRN:  if (last_tick) state_next = ST_EW_YEL;
      ST_EW_YEL:  if (last_tick) state_next = ST_EW_RED;
`ifdef FLASH_MODE_EN
      // Flashing runs tick by tick with no duration; leave only at a tick boundary.
      ST_FLASH:      if (tick && !bus.flash_req) state_next = ST_FLASH_EXIT;
      ST_FLASH_EXIT: if (last_tick) state_next = ns_entry;
`endif
      default:    state_next = ST_INIT;
    endcase
    advance = (state_next != state);
`ifdef FLASH_MODE_EN
    if (advance) begin
      flash_lit_next = 1'b1;
    end else if (state == ST_FLASH && tick) begin
      flash_lit_next = !flash_lit;
    end
    code_next = (state_next == ST_FLASH && !flash_lit_next) ? FLASH_DARK : code_of(state_next);
`else
    code_next = code_of(state_next);
`endif
  end

  // State register; outputs are registered alongside so they never lag the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_INIT;
      sec           <= '0;
      ns_pend       <= 1'b0;
      ew_pend       <= 1'b0;
      light_code_q  <= code_of(ST_INIT);
      phase_start_q <= 1'b1;
`ifdef FLASH_MODE_EN
      flash_lit     <= 1'b1;
`endif
    end else begin
      state         <= state_next;
      sec           <= advance ? 8'd0 : (tick ? sec + 8'd1 : sec);
      light_code_q  <= code_next;
      phase_start_q <= advance;
      // A request in the same cycle as the clear keeps the demand alive.
      ns_pend       <= bus.ns_left_req | (ns_pend & ~(phase_start_q && state == ST_NS_LGRN));
      ew_pend       <= bus.ew_left_req | (ew_pend & ~(phase_start_q && state == ST_EW_LGRN));
`ifdef FLASH_MODE_EN
      flash_lit     <= flash_lit_next;
`endif
    end
  end

  assign bus.light_code  = light_code_q;
  assign bus.phase       = state;
  assign bus.phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized bench for traffic_light_ctrl with a phase/cycle-budget reference model.
module tb_traffic_light_ctrl;

  localparam int T = 4, G = 3, Y = 2, L = 2, R = 1;
  localparam int P_INIT = 0, P_NLG = 1, P_NLY = 2, P_NG = 3, P_NY = 4, P_NR = 5;
  localparam int P_ELG = 6, P_ELY = 7, P_EG = 8, P_EY = 9, P_ER = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  traffic_light_ctrl_if bus();

  traffic_light_ctrl #(
    .TICK_CYCLES(T), .GREEN_S(G), .YELLOW_S(Y), .LEFT_S(L), .ALLRED_S(R)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: current phase, cycles left in it, entry flag, pending demands.
  int m_phase, m_left;
  bit m_start, m_nsp, m_ewp;

  function automatic int m_cycles(input int p);
    case (p)
      P_NLG, P_ELG:              return L * T;
      P_NLY, P_NY, P_ELY, P_EY:  return Y * T;
      P_NG, P_EG:                return G * T;
      default:                   return R * T;
    endcase
  endfunction

  function automatic logic [15:0] m_code(input int p);
    case (p)
      P_NLG: return 16'h3322;
      P_NLY: return 16'h4422;
      P_NG:  return 16'h0022;
      P_NY:  return 16'h1122;
      P_ELG: return 16'h2233;
      P_ELY: return 16'h2244;
      P_EG:  return 16'h2200;
      P_EY:  return 16'h2211;
      default: return 16'h2222;
    endcase
  endfunction

  function automatic void m_reset();
    m_phase = P_INIT;
    m_left  = m_cycles(P_INIT);
    m_start = 1'b1;
    m_nsp   = 1'b0;
    m_ewp   = 1'b0;
  endfunction

  function automatic void m_step(input bit ns, input bit ew);
    bit clr_ns, clr_ew;
    int nxt;
    clr_ns = m_start && (m_phase == P_NLG);
    clr_ew = m_start && (m_phase == P_ELG);
    if (m_left == 1) begin
      case (m_phase)
        P_NLG:   nxt = P_NLY;
        P_NLY:   nxt = P_NG;
        P_NG:    nxt = P_NY;
        P_NY:    nxt = P_NR;
        P_NR:    nxt = m_ewp ? P_ELG : P_EG;
        P_ELG:   nxt = P_ELY;
        P_ELY:   nxt = P_EG;
        P_EG:    nxt = P_EY;
        P_EY:    nxt = P_ER;
        default: nxt = m_nsp ? P_NLG : P_NG;
      endcase
      m_phase = nxt;
      m_left  = m_cycles(nxt);
      m_start = 1'b1;
    end else begin
      m_left  = m_left - 1;
      m_start = 1'b0;
    end
    m_nsp = ns | (m_nsp & !clr_ns);
    m_ewp = ew | (m_ewp & !clr_ew);
  endfunction

  task automatic cyc(input bit r, input bit ns, input bit ew);
    reset = r;
    bus.ns_left_req = ns;
    bus.ew_left_req = ew;
    @(posedge clk);
    if (r) m_reset(); else m_step(ns, ew);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0);
      checks++;
      if (bus.light_code !== 16'h2222 || bus.phase !== 4'd0 || bus.phase_start !== 1'b1) begin
        errors++;
        $display("FAIL reset%0d code=%h phase=%0d ps=%b want 2222/0/1", i, bus.light_code, bus.phase, bus.phase_start);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      checks++;
      if (bus.light_code !== 16'h2222 || bus.phase_start !== 1'b0) begin
        errors++;
        $display("FAIL init_hold%0d code=%h ps=%b want 2222/0", i, bus.light_code, bus.phase_start);
      end
    end
    cyc(0, 0, 0);
    checks++;
    if (bus.light_code !== 16'h0022 || bus.phase_start !== 1'b1) begin
      errors++;
      $display("FAIL first_green code=%h ps=%b want 0022/1", bus.light_code, bus.phase_start);
    end
    cyc(0, 0, 0);
    checks++;
    if (bus.light_code !== 16'h0022 || bus.phase_start !== 1'b0) begin
      errors++;
      $display("FAIL green_pulse code=%h ps=%b want 0022/0", bus.light_code, bus.phase_start);
    end
  endtask

  task automatic test_no_req();
    logic [15:0] hist [100];
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 0);
      hist[i] = bus.light_code;
      checks++;
      if (bus.light_code !== m_code(m_phase) || bus.phase_start !== m_start) begin
        errors++;
        $display("FAIL no_req cyc%0d code=%h ps=%b want %h/%b", i, bus.light_code, bus.phase_start, m_code(m_phase), m_start);
      end
      if (i >= 48) begin
        checks++;
        if (hist[i] !== hist[i-48]) begin
          errors++;
          $display("FAIL period48 cyc%0d code=%h want %h", i, hist[i], hist[i-48]);
        end
      end
    end
  endtask

  task automatic test_ns_left();
    int n3 = 0, n4 = 0;
    for (int i = 0; i < 200 && bus.light_code !== 16'h2200; i++) cyc(0, 0, 0);
    checks++;
    if (bus.light_code !== 16'h2200) begin
      errors++;
      $display("FAIL wait_ew_grn code=%h want 2200", bus.light_code);
    end
    cyc(0, 1, 0);
    for (int i = 0; i < 150; i++) begin
      cyc(0, 0, 0);
      if (bus.light_code === 16'h3322) n3++;
      if (bus.light_code === 16'h4422) n4++;
      checks++;
      if (bus.light_code !== m_code(m_phase) || bus.phase_start !== m_start) begin
        errors++;
        $display("FAIL ns_left cyc%0d code=%h ps=%b want %h/%b", i, bus.light_code, bus.phase_start, m_code(m_phase), m_start);
      end
    end
    checks++;
    if (n3 != 8 || n4 != 8) begin
      errors++;
      $display("FAIL ns_left_len lgrn=%0d lyel=%0d want 8/8", n3, n4);
    end
  endtask

  task automatic test_left_on_entry();
    int n3 = 0, hits = 0;
    bit req = 1'b0;
    cyc(0, 1, 0);
    for (int i = 0; i < 250; i++) begin
      cyc(0, req, 0);
      checks++;
      if (bus.light_code !== m_code(m_phase) || bus.phase_start !== m_start) begin
        errors++;
        $display("FAIL entry_req cyc%0d code=%h ps=%b want %h/%b", i, bus.light_code, bus.phase_start, m_code(m_phase), m_start);
      end
      if (bus.light_code === 16'h3322) n3++;
      req = (bus.light_code === 16'h3322) && bus.phase_start && (hits == 0);
      if (req) hits++;
    end
    checks++;
    if (n3 != 16 || hits != 1) begin
      errors++;
      $display("FAIL entry_req_len lgrn=%0d hits=%0d want 16/1", n3, hits);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200 && bus.light_code !== 16'h1122; i++) cyc(0, 0, 0);
    checks++;
    if (bus.light_code !== 16'h1122) begin
      errors++;
      $display("FAIL wait_ns_yel code=%h want 1122", bus.light_code);
    end
    for (int i = $urandom_range(0, 6); i > 0; i--) cyc(0, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if (bus.light_code !== 16'h2222 || bus.phase !== 4'd0 || bus.phase_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset code=%h phase=%0d ps=%b want 2222/0/1", bus.light_code, bus.phase, bus.phase_start);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      checks++;
      if (bus.light_code !== 16'h2222 || bus.phase_start !== 1'b0) begin
        errors++;
        $display("FAIL mid_init%0d code=%h ps=%b want 2222/0", i, bus.light_code, bus.phase_start);
      end
    end
    cyc(0, 0, 0);
    checks++;
    if (bus.light_code !== 16'h0022 || bus.phase_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_green code=%h ps=%b want 0022/1", bus.light_code, bus.phase_start);
    end
  endtask

  task automatic test_random();
    bit ns, ew, r;
    logic [3:0] nn, en;
    for (int i = 0; i < 600; i++) begin
      ns = ($urandom_range(0, 19) == 0);
      ew = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 199) == 0);
      cyc(r, ns, ew);
      checks++;
      if (bus.light_code !== m_code(m_phase) || bus.phase_start !== m_start) begin
        errors++;
        $display("FAIL random cyc%0d code=%h ps=%b want %h/%b", i, bus.light_code, bus.phase_start, m_code(m_phase), m_start);
      end
      nn = bus.light_code[15:12];
      en = bus.light_code[7:4];
      checks++;
      if (nn != 4'd2 && en != 4'd2) begin
        errors++;
        $display("FAIL conflict cyc%0d code=%h want one axis red", i, bus.light_code);
      end
    end
  endtask

`ifdef FLASH_MODE_EN
  task automatic expect_run(input logic [15:0] code, input int n, input bit first_ps, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0 || tag != "dark") cyc(0, 0, 0);
      checks++;
      if (bus.light_code !== code || bus.phase_start !== (i == 0 ? first_ps : 1'b0)) begin
        errors++;
        $display("FAIL flash_%s%0d code=%h ps=%b want %h", tag, i, bus.light_code, bus.phase_start, code);
      end
    end
  endtask

  task automatic test_flash();
    bus.flash_req = 1'b0;
    cyc(1, 0, 0);
    for (int i = 0; i < 20 && bus.light_code !== 16'h0022; i++) cyc(0, 0, 0);
    bus.flash_req = 1'b1;
    for (int i = 0; i < 60 && bus.light_code !== 16'h2222; i++) cyc(0, 0, 0);
    checks++;
    if (bus.light_code !== 16'h2222 || bus.phase_start !== 1'b1) begin
      errors++;
      $display("FAIL flash_wait_red code=%h ps=%b want 2222/1", bus.light_code, bus.phase_start);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    expect_run(16'h1122, 4, 1'b1, "lit");
    cyc(0, 0, 0);
    bus.flash_req = 1'b0;
    expect_run(16'h5555, 4, 1'b0, "dark");
    expect_run(16'h2222, 4, 1'b1, "exit");
    expect_run(16'h0022, 1, 1'b1, "green");
  endtask
`endif

  initial begin
    bus.ns_left_req = 1'b0;
    bus.ew_left_req = 1'b0;
`ifdef FLASH_MODE_EN
    bus.flash_req = 1'b0;
`endif
    m_reset();
    test_reset();
    test_no_req();
    test_ns_left();
    test_left_on_entry();
    test_reset_mid();
    test_random();
`ifdef FLASH_MODE_EN
    test_flash();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Four-way intersection sequencer that drives the 16-bit light-code word consumed by the 4-digit seven-segment display driver.
- Nibble per approach: [15:12] North, [11:8] South, [7:4] East, [3:0] West.
- Cycles NS and EW axes through optional protected-left, through-green, yellow and all-red clearance phases.
- Phase times are counted in whole seconds from an internal prescaler.
- Left-turn phases are served only when a latched request exists.

Parameters:
TICK_CYCLES, 100000000, clk cycles per second tick (benches override small); must be ≥1
GREEN_S, 10, through-green duration in ticks (≥1)
YELLOW_S, 3, through-yellow and left-yellow duration in ticks (≥1)
LEFT_S, 5, protected-left green duration in ticks (≥1)
ALLRED_S, 1, all-red clearance and INIT duration in ticks (≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ns_left_req  input  1  NS left-turn demand; sampled every cycle, sticky-latched
ew_left_req  input  1  EW left-turn demand; sampled every cycle, sticky-latched
light_code  output  16  four 4-bit light codes to the display driver, registered
phase  output  4  current state encoding, registered
phase_start  output  1  one-cycle pulse on the first cycle of every new state

Behaviour:
- Codes: GRE=0, YEL=1, RED=2, LFTGRE=3, LFTYEL=4, ALLOFF=5.
- States and light_code values:
  - INIT 0x2222
  - NS_LGRN 0x3322, NS_LYEL 0x4422, NS_GRN 0x0022, NS_YEL 0x1122, NS_RED 0x2222
  - EW_LGRN 0x2233, EW_LYEL 0x2244, EW_GRN 0x2200, EW_YEL 0x2211, EW_RED 0x2222
- Transitions:
  - INIT→(ns_pend ? NS_LGRN : NS_GRN); NS_LGRN→NS_LYEL→NS_GRN→NS_YEL→NS_RED.
  - NS_RED→(ew_pend ? EW_LGRN : EW_GRN); EW_LGRN→EW_LYEL→EW_GRN→EW_YEL→EW_RED.
  - EW_RED→(ns_pend ? NS_LGRN : NS_GRN).
- Durations: LGRN=LEFT_S, LYEL/YEL=YELLOW_S, GRN=GREEN_S, RED/INIT=ALLRED_S ticks.
- Timing: every state lasts exactly duration×TICK_CYCLES clk cycles.
  - Prescaler and second counter restart on the state-entry cycle.
  - Transition occurs on the cycle after the last cycle of the final tick.
- light_code, phase and phase_start are registered together with the state: zero lag between them.
- Pending flags ns_pend/ew_pend:
  - Set by the request input and cleared on entry to own-axis LGRN.
  - If set and clear coincide, set wins (demand is never lost).
  - Re-assertion during own LGRN/LYEL is held and served next cycle of that axis.
- Reset (any cycle, including mid-phase):
  - Next cycle state=INIT, light_code=0x2222, phase=INIT encoding (0).
  - phase_start=1 (INIT entry), pends cleared, prescaler and second counter zeroed.
- Never two conflicting greens: every axis change passes through a RED state.
- Counter widths: $clog2(TICK_CYCLES) for the prescaler; 8 bits for seconds (durations ≤255).

Optional Feature:
FLASH_MODE_EN
- Defined:
  - Adds input flash_req (1 bit) and states FLASH and FLASH_EXIT.
  - flash_req high is honoured at the next *_RED or INIT boundary: enter FLASH instead of the next green.
  - In FLASH, each tick toggles: NS YEL/ALLOFF (0x11xx↔0x55xx) and EW RED/ALLOFF (0xxx22↔0xxx55); it starts with the lit pattern 0x1122.
  - On flash_req low, complete the current tick, then spend ALLRED_S ticks in FLASH_EXIT (0x2222), then go to NS_GRN or NS_LGRN per ns_pend.
- Undefined: no port, no states; behaviour exactly as above.

Decomposition:
- Shared package traffic_pkg:
  - Light-code localparams (GRE..ALLOFF).
  - State encodings.
  - Per-state light_code constant function.
  - Default durations.
- One sub-module, sec_tick_gen (prescaler with restart input, 1-cycle tick output), instantiated once.

Test Plan:
Bench parameters: TICK_CYCLES=4, GREEN_S=3, YELLOW_S=2, LEFT_S=2, ALLRED_S=1.
1. Reset 2 cycles, no requests → light_code=0x2222 for 4 cycles, then 0x0022 with phase_start high for exactly 1 cycle.
2. No requests, run 100 cycles → sequence 0x0022(12 cycles)/0x1122(8)/0x2222(4)/0x2200(12)/0x2211(8)/0x2222(4); period 48 cycles.
3. 1-cycle ns_left_req pulse during EW_GRN → after EW_RED: 0x3322(8), 0x4422(8), then 0x0022; next NS cycle has no left phase.
4. ns_left_req high on the NS_LGRN entry cycle → left phase served now and again on the following NS cycle.
5. reset asserted mid NS_YEL → next cycle 0x2222, phase=0, phase_start=1; INIT lasts exactly 4 cycles.
6. FLASH_MODE_EN: flash_req high during NS_GRN → after NS_YEL/NS_RED, 0x1122↔0x5555 every 4 cycles; drop flash_req → 0x2222 for 4 cycles, then 0x0022.
